// File: rtl/saxi_write_slave.sv
// saxi_write_slave: SAXI write slave with independent AW/W buffering,
// in-order AW/W pairing and tagged B responses.
module saxi_ws_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  ram [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) ram[wp] <= din;
  end

  assign dout = ram[rp];
endmodule

module saxi_write_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int AW_DEPTH  = 4,
  parameter int W_DEPTH   = 4,
  parameter int B_DEPTH   = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [ID_W-1:0]              awid,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_W-1:0]              bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata
);
  localparam int MA_W = $clog2(MEM_WORDS);
  localparam int AC   = $clog2(AW_DEPTH) + 1;
  localparam int WC   = $clog2(W_DEPTH) + 1;
  localparam int BC   = $clog2(B_DEPTH) + 1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } aw_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  aw_t               aw_in;
  aw_t               aw_head;
  logic [DATA_W-1:0] w_head;
  b_t                b_in;
  b_t                b_head;

  logic [AC-1:0] aw_cnt;
  logic [AC-1:0] aw_nxt;
  logic [WC-1:0] w_cnt;
  logic [WC-1:0] w_nxt;
  logic [BC-1:0] b_cnt;

  logic aw_push;
  logic w_push;
  logic b_pop;
  logic b_room;
  logic commit;
  logic misal;
  logic oor;
  logic [1:0] resp;
  logic [ADDR_W-3:0] word;

  assign aw_push = awvalid & awready;
  assign w_push  = wvalid & wready;
  assign b_pop   = bvalid & bready;

  // A full B FIFO still accepts a commit when its head leaves this edge.
  assign b_room = (b_cnt != BC'(B_DEPTH)) | b_pop;
  assign commit = (aw_cnt != '0) & (w_cnt != '0) & b_room;

  assign aw_in = '{id: awid, addr: awaddr};

  saxi_ws_fifo #(.W(ADDR_W + ID_W), .DEPTH(AW_DEPTH)) u_aw (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_push),
    .pop   (commit),
    .din   (aw_in),
    .dout  (aw_head),
    .count (aw_cnt)
  );

  saxi_ws_fifo #(.W(DATA_W), .DEPTH(W_DEPTH)) u_w (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (commit),
    .din   (wdata),
    .dout  (w_head),
    .count (w_cnt)
  );

  assign word  = aw_head.addr[ADDR_W-1:2];
  assign misal = |aw_head.addr[1:0];
  assign oor   = {1'b0, word} >= (ADDR_W-1)'(MEM_WORDS);

  // Misalignment takes precedence over an out-of-range word.
  always_comb begin
    resp = OKAY;
    if (misal)    resp = SLVERR;
    else if (oor) resp = DECERR;
  end

  assign b_in = '{id: aw_head.id, resp: resp};

  saxi_ws_fifo #(.W(ID_W + 2), .DEPTH(B_DEPTH)) u_b (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .pop   (b_pop),
    .din   (b_in),
    .dout  (b_head),
    .count (b_cnt)
  );

  assign bvalid = b_cnt != '0;
  assign bid    = bvalid ? b_head.id   : '0;
  assign bresp  = bvalid ? b_head.resp : '0;

  assign aw_nxt = aw_cnt + AC'(aw_push) - AC'(commit);
  assign w_nxt  = w_cnt + WC'(w_push) - WC'(commit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      awready   <= 1'b0;
      wready    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      awready <= aw_nxt != AC'(AW_DEPTH);
      wready  <= w_nxt != WC'(W_DEPTH);
      mem_we  <= commit & (resp == OKAY);
      if (commit & (resp == OKAY)) begin
        mem_addr  <= word[MA_W-1:0];
        mem_wdata <= w_head;
      end
    end
  end
endmodule
